// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants and the debug-dump FSM state type.
package mips_pkg;

    localparam int LEN       = 32;
    localparam int NB_ADDR   = 5;
    localparam int REG_COUNT = 2 ** NB_ADDR;
    localparam int REG_ZERO  = 0;

    typedef enum logic {
        DUMP_IDLE = 1'b0,
        DUMP_RUN  = 1'b1
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Dump sequencer: walks a pointer over every register index under a ready/valid handshake.
module regfile_dump_ctrl
    import mips_pkg::*;
#(
    parameter int NB_ADDR = mips_pkg::NB_ADDR
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_dump_start,
    input  logic               i_dump_ready,
    output logic               o_dump_valid,
    output logic               o_dump_last,
    output logic               o_dump_busy,
    output logic [NB_ADDR-1:0] o_dump_ptr
);

    dump_state_t        state, state_nx;
    logic [NB_ADDR-1:0] ptr, ptr_nx;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= DUMP_IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        o_dump_valid = 1'b0;
        o_dump_last  = 1'b0;
        o_dump_busy  = 1'b0;
        case (state)
            DUMP_IDLE: begin
                if (i_dump_start) begin
                    state_nx = DUMP_RUN;
                    ptr_nx   = '0;
                end
            end
            DUMP_RUN: begin
                o_dump_valid = 1'b1;
                o_dump_busy  = 1'b1;
                o_dump_last  = (ptr == {NB_ADDR{1'b1}});
                // Start requests are deliberately ignored here, including on the final transfer.
                if (i_dump_ready) begin
                    if (o_dump_last) begin
                        state_nx = DUMP_IDLE;
                        ptr_nx   = '0;
                    end else begin
                        ptr_nx = ptr + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = DUMP_IDLE;
                ptr_nx   = '0;
            end
        endcase
    end

    assign o_dump_ptr = ptr;

endmodule

// File: rtl/register_file_wb_sink.sv
// MIPS 32x32 register file fed by the write-back bus, with two decode read ports and a debug dump port.
// Optional same-cycle write-through forwarding: define REGFILE_WRITE_BYPASS_EN.
module register_file_wb_sink
    import mips_pkg::*;
#(
    parameter int LEN     = mips_pkg::LEN,
    parameter int NB_ADDR = mips_pkg::NB_ADDR
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_RegWrite,
    input  logic [NB_ADDR-1:0] i_write_register,
    input  logic [LEN-1:0]     i_write_data,
    input  logic [NB_ADDR-1:0] i_read_register_1,
    input  logic [NB_ADDR-1:0] i_read_register_2,
    output logic [LEN-1:0]     o_read_data_1,
    output logic [LEN-1:0]     o_read_data_2,
    input  logic               i_dump_start,
    input  logic               i_dump_ready,
    output logic               o_dump_valid,
    output logic [NB_ADDR-1:0] o_dump_addr,
    output logic [LEN-1:0]     o_dump_data,
    output logic               o_dump_last,
    output logic               o_dump_busy
);

    localparam int DEPTH = 2 ** NB_ADDR;

    logic [LEN-1:0]     regs [DEPTH];
    logic [NB_ADDR-1:0] dump_ptr;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (i_RegWrite && (i_write_register != NB_ADDR'(REG_ZERO))) begin
            regs[i_write_register] <= i_write_data;
        end
    end

    // Shared by both decode ports and the dump port so they agree on r0 and forwarding.
    function automatic logic [LEN-1:0] read_mux(input logic [NB_ADDR-1:0] addr,
                                                input logic [LEN-1:0]     stored);
        logic [LEN-1:0] val;
        val = stored;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (i_RegWrite && (addr == i_write_register)) begin
            val = i_write_data;
        end
`endif
        if (addr == NB_ADDR'(REG_ZERO)) begin
            val = '0;
        end
        return val;
    endfunction

    always_comb begin
        o_read_data_1 = read_mux(i_read_register_1, regs[i_read_register_1]);
        o_read_data_2 = read_mux(i_read_register_2, regs[i_read_register_2]);
        o_dump_data   = read_mux(dump_ptr, regs[dump_ptr]);
    end

    regfile_dump_ctrl #(
        .NB_ADDR(NB_ADDR)
    ) u_dump_ctrl (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_dump_start(i_dump_start),
        .i_dump_ready(i_dump_ready),
        .o_dump_valid(o_dump_valid),
        .o_dump_last (o_dump_last),
        .o_dump_busy (o_dump_busy),
        .o_dump_ptr  (dump_ptr)
    );

    assign o_dump_addr = dump_ptr;

endmodule

// File: tb/tb_register_file_wb_sink.sv
// Self-checking bench for register_file_wb_sink; honours REGFILE_WRITE_BYPASS_EN when defined.
module tb_register_file_wb_sink;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_RegWrite;
    logic [4:0]  i_write_register;
    logic [31:0] i_write_data;
    logic [4:0]  i_read_register_1;
    logic [4:0]  i_read_register_2;
    logic [31:0] o_read_data_1;
    logic [31:0] o_read_data_2;
    logic        i_dump_start;
    logic        i_dump_ready;
    logic        o_dump_valid;
    logic [4:0]  o_dump_addr;
    logic [31:0] o_dump_data;
    logic        o_dump_last;
    logic        o_dump_busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] model [32];

    always #5 i_clk = ~i_clk;

    register_file_wb_sink dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_RegWrite       (i_RegWrite),
        .i_write_register (i_write_register),
        .i_write_data     (i_write_data),
        .i_read_register_1(i_read_register_1),
        .i_read_register_2(i_read_register_2),
        .o_read_data_1    (o_read_data_1),
        .o_read_data_2    (o_read_data_2),
        .i_dump_start     (i_dump_start),
        .i_dump_ready     (i_dump_ready),
        .o_dump_valid     (o_dump_valid),
        .o_dump_addr      (o_dump_addr),
        .o_dump_data      (o_dump_data),
        .o_dump_last      (o_dump_last),
        .o_dump_busy      (o_dump_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value any reader of address a should see right now.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (i_RegWrite && (i_write_register == a)) return i_write_data;
`endif
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Advance one clock, mirroring the write-back into the model; returns at the falling edge.
    task automatic tick();
        @(posedge i_clk);
        if (i_reset) clear_model();
        else if (i_RegWrite && i_write_register != 5'd0) model[i_write_register] = i_write_data;
        @(negedge i_clk);
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        i_RegWrite = 1'b1;
        i_write_register = a;
        i_write_data = d;
        tick();
        i_RegWrite = 1'b0;
    endtask

    task automatic check_reads(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        i_read_register_1 = a1;
        i_read_register_2 = a2;
        #1;
        check({tag, "_p1"}, o_read_data_1, exp_read(a1));
        check({tag, "_p2"}, o_read_data_2, exp_read(a2));
    endtask

    // mode 0: ready held high; 1: toggling ready with a stalled write to r10; 2: random ready.
    // abort_at >= 0 asserts reset when that word is presented.
    task automatic run_dump(input string tag, input int mode, input int abort_at);
        int  exp_addr = 0;
        int  transfers = 0;
        int  cycles = 0;
        bit  done = 1'b0;
        bit  wrote10 = 1'b0;
        i_dump_start = 1'b1;
        tick();
        i_dump_start = 1'b0;
        while (!done && cycles < 400) begin
            cycles++;
            if (exp_addr == abort_at) begin
                i_reset = 1'b1;
                clear_model();
                #1;
                check({tag, "_abort_valid"}, {31'h0, o_dump_valid}, 32'h0);
                check({tag, "_abort_busy"}, {31'h0, o_dump_busy}, 32'h0);
                tick();
                i_reset = 1'b0;
                tick();
                return;
            end
            case (mode)
                0:       i_dump_ready = 1'b1;
                1:       i_dump_ready = cycles[0];
                default: i_dump_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 1 && exp_addr == 10 && !wrote10) begin
                i_dump_ready = 1'b0;
                i_RegWrite = 1'b1;
                i_write_register = 5'd10;
                i_write_data = 32'hCAFE0000;
                wrote10 = 1'b1;
            end
            if (mode == 1 && exp_addr == 5) i_dump_start = 1'b1;
            if (mode == 0 && exp_addr == 31) i_dump_start = 1'b1;
            #1;
            check({tag, "_valid"}, {31'h0, o_dump_valid}, 32'h1);
            check({tag, "_busy"}, {31'h0, o_dump_busy}, 32'h1);
            check({tag, "_addr"}, {27'h0, o_dump_addr}, exp_addr);
            check({tag, "_data"}, o_dump_data, exp_read(5'(exp_addr)));
            check({tag, "_last"}, {31'h0, o_dump_last}, {31'h0, exp_addr == 31});
            if (mode == 1 && exp_addr == 10 && i_dump_ready)
                check({tag, "_word10"}, o_dump_data, 32'hCAFE0000);
            if (i_dump_ready) begin
                transfers++;
                if (exp_addr == 31) done = 1'b1;
                else exp_addr++;
            end
            tick();
            i_RegWrite = 1'b0;
            i_dump_start = 1'b0;
        end
        check({tag, "_completed"}, {31'h0, done}, 32'h1);
        check({tag, "_transfers"}, transfers, 32);
        i_dump_ready = 1'b0;
        #1;
        check({tag, "_idle_valid"}, {31'h0, o_dump_valid}, 32'h0);
        check({tag, "_idle_busy"}, {31'h0, o_dump_busy}, 32'h0);
    endtask

    initial begin
        logic [4:0]  ra, rb;
        logic [31:0] rd;
        i_reset = 1'b1;
        i_RegWrite = 1'b0;
        i_write_register = '0;
        i_write_data = '0;
        i_read_register_1 = '0;
        i_read_register_2 = '0;
        i_dump_start = 1'b0;
        i_dump_ready = 1'b0;
        clear_model();
        tick();
        #1;
        check("rst_valid", {31'h0, o_dump_valid}, 32'h0);
        check("rst_busy", {31'h0, o_dump_busy}, 32'h0);
        check("rst_last", {31'h0, o_dump_last}, 32'h0);
        check_reads("rst_read", 5'd3, 5'd31);
        i_reset = 1'b0;
        tick();

        write_reg(5'd5, 32'hDEADBEEF);
        check_reads("r5", 5'd5, 5'd5);
        check("r5_const", o_read_data_1, 32'hDEADBEEF);
        write_reg(5'd0, 32'h12345678);
        check_reads("r0", 5'd0, 5'd0);
        check("r0_const", o_read_data_2, 32'h0);

        write_reg(5'd7, 32'h1);
        i_RegWrite = 1'b1;
        i_write_register = 5'd7;
        i_write_data = 32'hA5A5A5A5;
        check_reads("hazard", 5'd7, 5'd5);
`ifdef REGFILE_WRITE_BYPASS_EN
        check("hazard_const", o_read_data_1, 32'hA5A5A5A5);
`else
        check("hazard_const", o_read_data_1, 32'h00000001);
`endif
        tick();
        i_RegWrite = 1'b0;
        check_reads("hazard_next", 5'd7, 5'd7);
        check("hazard_next_const", o_read_data_2, 32'hA5A5A5A5);

        for (int i = 0; i < 24; i++) begin
            ra = 5'($urandom_range(0, 31));
            rb = 5'($urandom_range(0, 31));
            rd = $urandom;
            i_RegWrite = 1'b1;
            i_write_register = 5'($urandom_range(0, 31));
            i_write_data = rd;
            if (i % 3 == 0) i_write_register = ra;
            check_reads("rand", ra, rb);
            tick();
        end
        i_RegWrite = 1'b0;

        i_reset = 1'b1;
        clear_model();
        check_reads("midrst", 5'd5, 5'd7);
        check("midrst_valid", {31'h0, o_dump_valid}, 32'h0);
        check("midrst_busy", {31'h0, o_dump_busy}, 32'h0);
        tick();
        i_reset = 1'b0;
        tick();

        for (int i = 0; i < 32; i++) write_reg(5'(i), 32'(i * 32'h11));
        run_dump("dump_const", 0, -1);
        run_dump("dump_bp", 1, -1);
        for (int i = 1; i < 32; i++) write_reg(5'(i), $urandom);
        run_dump("dump_rand", 2, -1);
        run_dump("dump_abort", 0, 12);
        for (int i = 1; i < 32; i += 3) write_reg(5'(i), $urandom);
        run_dump("dump_after", 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
